// File: rtl/issue_sequencer_pkg.sv
// Shared types and constants for the issue sequencer: branch count, commit-ID sizing, FSM states.
package issue_sequencer_pkg;

   localparam int unsigned N_INSTR_BRANCHES = 4;
   localparam int unsigned BRANCH_W         = $clog2(N_INSTR_BRANCHES);
   localparam int unsigned COMMIT_ID_WIDTH  = 2;
   localparam int unsigned INFLIGHT_LIMIT   = 1 << COMMIT_ID_WIDTH;
   localparam int unsigned INFLIGHT_W       = COMMIT_ID_WIDTH + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_e;

   // One-hot strobe for the decoded target branch.
   function automatic logic [N_INSTR_BRANCHES-1:0] branch_onehot(input logic [BRANCH_W-1:0] br);
      return N_INSTR_BRANCHES'(1) << br;
   endfunction

endpackage

// File: rtl/issue_sequencer_if.sv
// Fetch-side and issue-side handshake bundle between the sequencer and its neighbours.
interface issue_sequencer_if
   import issue_sequencer_pkg::*;
#(
   parameter int unsigned n_blocks    = 256,
   parameter int unsigned instr_width = 32
);
   localparam int unsigned BLK_W = $clog2(n_blocks);

   logic [BLK_W-1:0]            fetch_block;
   logic                        fetch_valid;
   logic [instr_width-1:0]      fetch_instr;
   logic [BRANCH_W-1:0]         fetch_branch;
   logic                        fetch_ready;
   logic [N_INSTR_BRANCHES-1:0] out_valid;
   logic [N_INSTR_BRANCHES-1:0] out_ready;
   logic [instr_width-1:0]      out_instr;
   logic [BLK_W-1:0]            out_block;
   logic [COMMIT_ID_WIDTH-1:0]  out_commit_id;

   modport master (
      output fetch_block, fetch_ready, out_valid, out_instr, out_block, out_commit_id,
      input  fetch_valid, fetch_instr, fetch_branch, out_ready
   );

   modport slave (
      input  fetch_block, fetch_ready, out_valid, out_instr, out_block, out_commit_id,
      output fetch_valid, fetch_instr, fetch_branch, out_ready
   );

endinterface

// File: rtl/issue_sequencer_inflight_counter.sv
// Saturating up/down count of issued-but-uncommitted instructions.
module inflight_counter #(
   parameter int unsigned width     = 3,
   parameter int unsigned max_count = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec,
   output logic [width-1:0] count
);

   // Simultaneous inc and dec cancel; dec at zero and inc at max are ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (inc && !dec && (count < width'(max_count))) begin
         count <= count + width'(1);
      end else if (dec && !inc && (count != '0)) begin
         count <= count - width'(1);
      end
   end

endmodule

// File: rtl/issue_sequencer.sv
// Walks the active program blocks once per sample tick, issuing each fetched instruction
// to its decoded branch with a commit ID, and throttles on the number of in-flight instructions.
module issue_sequencer
   import issue_sequencer_pkg::*;
#(
   parameter int unsigned n_blocks    = 256,
   parameter int unsigned instr_width = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       sample_tick,
   input  logic [$clog2(n_blocks):0]  n_active_blocks,
   input  logic                       commit_pulse,
   output logic                       busy,
   output logic                       pass_done,
   output logic                       overrun,
   issue_sequencer_if.master          bus
);

   localparam int unsigned BLK_W = $clog2(n_blocks);

   seq_state_e                 state_q, state_d;
   logic [BLK_W-1:0]           blk_q, blk_d;
   logic [COMMIT_ID_WIDTH-1:0] id_q, id_d;
   logic                       overrun_q, overrun_d;
   logic [INFLIGHT_W-1:0]      inflight;
   logic                       issue_ok;
   logic                       handshake;
   logic                       last_block;

   assign issue_ok   = (state_q == ST_ISSUE) && enable && bus.fetch_valid &&
                       (inflight < INFLIGHT_W'(INFLIGHT_LIMIT));
   assign handshake  = issue_ok && bus.out_ready[bus.fetch_branch];
   assign last_block = ((BLK_W+1)'(blk_q) + (BLK_W+1)'(1)) >= n_active_blocks;

   assign bus.fetch_block   = blk_q;
   assign bus.fetch_ready   = handshake;
   assign bus.out_valid     = issue_ok ? branch_onehot(bus.fetch_branch) : '0;
   assign bus.out_instr     = bus.fetch_instr;
   assign bus.out_block     = blk_q;
   assign bus.out_commit_id = id_q;

   assign busy      = (state_q != ST_IDLE);
   assign pass_done = (state_q == ST_DONE) && enable;
   assign overrun   = overrun_q;

   inflight_counter #(
      .width     (INFLIGHT_W),
      .max_count (INFLIGHT_LIMIT)
   ) u_inflight (
      .clk   (clk),
      .reset (reset),
      .inc   (handshake),
      .dec   (commit_pulse),
      .count (inflight)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         blk_q     <= '0;
         id_q      <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         blk_q     <= blk_d;
         id_q      <= id_d;
         overrun_q <= overrun_d;
      end
   end

   // Next-state; the issue ID deliberately survives pass boundaries.
   always_comb begin
      state_d   = state_q;
      blk_d     = blk_q;
      id_d      = id_q;
      overrun_d = overrun_q;

      if (handshake) begin
         blk_d = blk_q + BLK_W'(1);
         id_d  = id_q + COMMIT_ID_WIDTH'(1);
      end

      unique case (state_q)
         ST_IDLE: begin
            if (enable && sample_tick) begin
               blk_d   = '0;
               state_d = (n_active_blocks == '0) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (sample_tick) overrun_d = 1'b1;
            if (handshake && last_block) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (sample_tick) overrun_d = 1'b1;
            if (enable && ((inflight == '0) ||
                           ((inflight == INFLIGHT_W'(1)) && commit_pulse))) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (enable) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_issue_sequencer.sv
// Randomized scoreboard bench for issue_sequencer: predicted issues are queued per pass and
// checked by a negedge monitor that also tracks the in-flight count and drives commits.
module tb_issue_sequencer;
   import issue_sequencer_pkg::*;

   localparam int unsigned NB    = 256;
   localparam int unsigned IW    = 32;
   localparam int          LIMIT = 1 << COMMIT_ID_WIDTH;

   typedef struct {
      int          blk;
      logic [31:0] instr;
      int          id;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset, enable, sample_tick, commit_pulse;
   logic [8:0] n_active;
   logic       busy, pass_done, overrun;
   logic       fv;
   logic [N_INSTR_BRANCHES-1:0] rdy;
   logic [31:0] prog [NB];

   exp_t exp_q[$];
   int   checks = 0, errors = 0;
   int   hs_count = 0, done_count = 0;
   int   inflight_m = 0, push_id = 0;
   int   cmode = 0;
   bit   man_commit = 0, coincide_fired = 0;
   bit   [1:0] pipe = '0;

   always #5 clk = ~clk;

   issue_sequencer_if #(.n_blocks(NB), .instr_width(IW)) bus ();

   assign bus.fetch_valid  = fv;
   assign bus.out_ready    = rdy;
   assign bus.fetch_instr  = prog[bus.fetch_block];
   assign bus.fetch_branch = prog[bus.fetch_block][BRANCH_W-1:0];

   issue_sequencer #(.n_blocks(NB), .instr_width(IW)) dut (
      .clk             (clk),
      .reset           (reset),
      .enable          (enable),
      .sample_tick     (sample_tick),
      .n_active_blocks (n_active),
      .commit_pulse    (commit_pulse),
      .busy            (busy),
      .pass_done       (pass_done),
      .overrun         (overrun),
      .bus             (bus)
   );

   task automatic check(input string name, input longint act, input longint want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
      end
   endtask

   // Monitor: scoreboard pop on every handshake, commit generation, in-flight model.
   always @(negedge clk) begin
      bit   hs, c;
      exp_t e;
      hs = (bus.fetch_ready === 1'b1) && (reset === 1'b0);
      if (hs) begin
         hs_count++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_issue: block %0d issued, expected no issue", bus.out_block);
         end else begin
            e = exp_q.pop_front();
            check("out_block", longint'(bus.out_block), e.blk);
            check("out_instr", longint'(bus.out_instr), longint'(e.instr));
            check("out_commit_id", longint'(bus.out_commit_id), e.id);
            check("out_valid_onehot", longint'(bus.out_valid), 1 << e.instr[BRANCH_W-1:0]);
         end
         check("inflight_below_limit", longint'(inflight_m < LIMIT), 1);
      end
      if (pass_done === 1'b1) begin
         done_count++;
         check("done_all_issued", exp_q.size(), 0);
      end
      c = man_commit || (cmode == 1 && pipe[1]) || (cmode == 2 && inflight_m > 0) ||
          (cmode == 3 && !coincide_fired && hs && inflight_m == 2);
      if (cmode == 3 && c) coincide_fired = 1'b1;
      commit_pulse = c;
      pipe = {pipe[0], hs};
      if (reset) begin
         inflight_m = 0;
         pipe       = '0;
      end else if (hs && !c) begin
         inflight_m++;
      end else if (!hs && c && inflight_m > 0) begin
         inflight_m--;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Tick from IDLE: every active block will issue once, in order, with consecutive IDs.
   task automatic start_pass(input int n);
      exp_t e;
      n_active = 9'(n);
      for (int k = 0; k < n; k++) begin
         e.blk   = k;
         e.instr = prog[k];
         e.id    = push_id % LIMIT;
         push_id++;
         exp_q.push_back(e);
      end
      enable      = 1'b1;
      sample_tick = 1'b1;
      cyc();
      sample_tick = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget, input bit rnd);
      int start;
      start = done_count;
      for (int i = 0; i < budget && done_count == start; i++) begin
         if (rnd) begin
            fv     = ($urandom % 4) != 0;
            rdy    = N_INSTR_BRANCHES'($urandom);
            enable = ($urandom % 8) != 0;
         end
         cyc();
      end
      enable = 1'b1;
      fv     = 1'b1;
      rdy    = '1;
      repeat (3) cyc();
      check(name, done_count - start, 1);
   endtask

   initial begin
      int          hs0, d0;
      logic [31:0] p0;
      for (int i = 0; i < NB; i++) prog[i] = $urandom;
      reset = 1'b1; enable = 1'b1; sample_tick = 1'b0; fv = 1'b1; rdy = '1; n_active = '0;
      repeat (3) cyc();
      check("reset_busy", busy, 0);
      check("reset_fetch_ready", bus.fetch_ready, 0);
      reset = 1'b0;
      cyc();
      check("idle_busy", busy, 0);
      check("idle_pass_done", pass_done, 0);
      check("idle_overrun", overrun, 0);
      check("idle_fetch_ready", bus.fetch_ready, 0);
      check("idle_out_valid", longint'(bus.out_valid), 0);
      check("idle_fetch_block", longint'(bus.fetch_block), 0);
      check("idle_commit_id", longint'(bus.out_commit_id), 0);

      // Two back-to-back 3-block passes with delayed commits; IDs continue across passes.
      cmode = 1;
      hs0 = hs_count;
      start_pass(3);
      wait_done("passA_done_once", 60, 1'b0);
      start_pass(3);
      wait_done("passB_done_once", 60, 1'b0);
      check("passAB_issues", hs_count - hs0, 6);

      // Target branch not ready: issue strobe held, nothing advances.
      rdy = '0;
      hs0 = hs_count;
      p0  = prog[0];
      start_pass(2);
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("stall_out_valid", longint'(bus.out_valid), 1 << p0[BRANCH_W-1:0]);
         check("stall_fetch_ready", bus.fetch_ready, 0);
         check("stall_fetch_block", longint'(bus.fetch_block), 0);
      end
      check("stall_no_issue", hs_count - hs0, 0);
      enable = 1'b0;
      cyc();
      check("disabled_out_valid", longint'(bus.out_valid), 0);
      check("disabled_fetch_ready", bus.fetch_ready, 0);
      enable = 1'b1;
      rdy    = '1;
      wait_done("stall_pass_done", 60, 1'b0);

      // No commits: in-flight limit stops issue; one commit admits exactly one more (ID wraps).
      cmode = 0;
      hs0 = hs_count;
      start_pass(6);
      repeat (10) cyc();
      check("limit_issues", hs_count - hs0, LIMIT);
      check("limit_fetch_ready", bus.fetch_ready, 0);
      check("limit_busy", busy, 1);
      man_commit = 1'b1; cyc(); man_commit = 1'b0;
      repeat (4) cyc();
      check("limit_one_more", hs_count - hs0, LIMIT + 1);
      check("limit_next_id", longint'(bus.out_commit_id), (push_id - 1) % LIMIT);
      man_commit = 1'b1; cyc(); man_commit = 1'b0;
      repeat (4) cyc();
      check("limit_all_issued", hs_count - hs0, 6);

      // Tick while draining: sticky overrun, no restart, single pass_done.
      sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
      check("drain_overrun", overrun, 1);
      check("drain_busy", busy, 1);
      cmode = 2;
      wait_done("drain_done_once", 60, 1'b0);
      check("drain_no_restart", hs_count - hs0, 6);
      check("drain_back_idle", busy, 0);
      check("overrun_sticky", overrun, 1);

      // Third issue coincides with a commit at two in flight: limit reached after five issues.
      cmode = 3;
      coincide_fired = 1'b0;
      hs0 = hs_count;
      start_pass(6);
      repeat (12) cyc();
      check("coincide_fired", coincide_fired, 1);
      check("coincide_issues", hs_count - hs0, 5);
      check("coincide_stalled", bus.fetch_ready, 0);
      cmode = 2;
      wait_done("coincide_done", 80, 1'b0);

      // Reset mid-pass after two issues: pass abandoned, IDs restart at zero.
      cmode = 1;
      fv = 1'b0;
      hs0 = hs_count;
      d0  = done_count;
      start_pass(5);
      fv = 1'b1; cyc(); cyc(); fv = 1'b0;
      check("reset_mid_issues", hs_count - hs0, 2);
      reset = 1'b1;
      exp_q.delete();
      push_id = 0;
      cyc();
      check("reset_mid_busy", busy, 0);
      check("reset_mid_block", longint'(bus.fetch_block), 0);
      check("reset_mid_id", longint'(bus.out_commit_id), 0);
      check("reset_mid_overrun", overrun, 0);
      reset = 1'b0;
      fv = 1'b1;
      repeat (4) cyc();
      check("reset_mid_no_done", done_count - d0, 0);
      check("reset_mid_idle", busy, 0);
      start_pass(2);
      wait_done("post_reset_pass", 60, 1'b0);

      // Zero active blocks: straight to done, nothing issued.
      hs0 = hs_count;
      start_pass(0);
      wait_done("zero_pass_done", 10, 1'b0);
      check("zero_pass_issues", hs_count - hs0, 0);

      // Randomized passes with random fetch/ready/enable gaps.
      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < 16; i++) prog[i] = $urandom;
         cmode = 1;
         start_pass(int'($urandom_range(0, 12)));
         wait_done("random_pass_done", 600, 1'b1);
      end
      check("final_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
      $fatal(1);
   end

endmodule
